clock_divider_multi: RTL

Parametrised successor to the single fixed 1 Hz divider: NUM_CH independent divider channels, all clocked from the 100 MHz board clock.
- Each channel has a runtime-loadable divisor, a per-channel enable, and two outputs: a one-cycle tick (clock enable) and a 50%-duty square wave.
- A global sync restarts every channel in phase.
- Feeds display refresh, debounce, and blink/timekeeping logic, replacing per-consumer divider copies.

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_channel.sv | 55 +++++
 rtl/clock_divider_multi.sv | 42 ++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider.
// Divisors assume the 100 MHz board clock.
package clk_div_pkg;

  localparam int DEF_CNT_W = 27;
  localparam int DEF_DIV   = 50_000_000;

  localparam int DIV_1HZ           = 50_000_000;
  localparam int DIV_2HZ           = 25_000_000;
  localparam int DIV_1KHZ          = 50_000;
  localparam int DIV_REFRESH_400HZ = 125_000;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, divisor register, tick and square wave.
// Precedence: reset, then sync, then load, then counting.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DIV_DEFAULT = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             load_hit,
  input  logic [CNT_W-1:0] load_div,
  output logic             tick,
  output logic             sq
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] last;

  // A divisor of 0 behaves as 1, so the terminal count is 0 for both.
  assign last = (div == '0) ? '0 : div - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      div  <= CNT_W'(DIV_DEFAULT);
      tick <= 1'b0;
      sq   <= 1'b0;
    end else if (sync) begin
      cnt  <= '0;
      tick <= 1'b0;
      sq   <= 1'b0;
      if (load_hit) div <= load_div;
    end else if (load_hit) begin
      cnt  <= '0;
      div  <= load_div;
      tick <= 1'b0;
    end else if (en) begin
      if (cnt == last) begin
        cnt  <= '0;
        tick <= 1'b1;
        sq   <= ~sq;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent dividers with shared sync and addressed load.
// Load addresses outside the channel range are dropped.
module clock_divider_multi
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int CNT_W       = DEF_CNT_W,
  parameter  int DIV_DEFAULT = DEF_DIV,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_div,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] sq_out
);

  logic [NUM_CH-1:0] load_hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load_hit[i] = load && (load_ch == CH_W'(i));

    clk_div_channel #(
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_ch (
      .clk      (clk),
      .reset    (RESET),
      .en       (en[i]),
      .sync     (sync),
      .load_hit (load_hit[i]),
      .load_div (load_div),
      .tick     (tick_out[i]),
      .sq       (sq_out[i])
    );
  end

endmodule
